// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte handshake and completion strobes for ps2_host_tx
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       done;
    logic       err;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  done,
        input  err
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output done,
        output err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter driving open-drain output-enables
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int REQ_CYCLES     = 200,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave host,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);
    localparam int MAX_A = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int MAX_P = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CW    = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] REQ_LAST = CW'(REQ_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    STOP_IDX = 4'd10;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        RELEASE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]    bit_cnt, bit_n, bit_inc;
    logic [7:0]    byte_q, byte_n;
    logic [2:0]    clk_s, data_s;
    logic          fall, timeout;
    logic          clk_oe_n, data_oe_n, done_n, err_n;
    logic          done_q, err_q;

    // Index 0 start, 1..8 data LSB first, 9 odd parity, 10 and beyond released (stop).
    function automatic logic frame_bit(input logic [3:0] k, input logic [7:0] d);
        if (k == 4'd0) begin
            return 1'b0;
        end else if (k <= 4'd8) begin
            return d[3'(k - 4'd1)];
        end else if (k == 4'd9) begin
            return ~^d;
        end else begin
            return 1'b1;
        end
    endfunction

    assign fall    = clk_s[2] & ~clk_s[1];
    assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
    assign bit_inc = (bit_cnt == 4'hF) ? bit_cnt : bit_cnt + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s  <= '0;
            data_s <= '0;
        end else begin
            clk_s  <= {clk_s[1:0], ps2_clk_in};
            data_s <= {data_s[1:0], ps2_data_in};
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt_inc;
        bit_n   = bit_cnt;
        byte_n  = byte_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        timeout = (cnt == TO_LAST);

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (host.tx_valid) begin
                    byte_n  = host.tx_data;
                    state_n = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == INH_LAST) begin
                    cnt_n   = '0;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (cnt == REQ_LAST) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (timeout) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (bit_cnt == STOP_IDX) begin
                    state_n = ACK;
                end else if (fall) begin
                    bit_n = bit_inc;
                end
            end
            ACK: begin
                if (timeout) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (fall) begin
                    if (data_s[2]) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (timeout) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (clk_s[2] & data_s[2]) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Pad enables follow the next state so they change with the state register, glitch-free.
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        unique case (state_n)
            INHIBIT: clk_oe_n = 1'b1;
            REQ: begin
                clk_oe_n  = 1'b1;
                data_oe_n = 1'b1;
            end
            SEND:    data_oe_n = ~frame_bit(bit_n, byte_n);
            default: data_oe_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            byte_q      <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_cnt     <= bit_n;
            byte_q      <= byte_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            done_q      <= done_n;
            err_q       <= err_n;
        end
    end

    assign host.tx_ready = (state == IDLE);
    assign host.done     = done_q;
    assign host.err      = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done_accept_cnt = 0;
    logic both_seen = 1'b0;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .REQ_CYCLES(4),
        .TIMEOUT_CYCLES(5000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .host(bus.slave),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.err) err_cnt++;
        if (bus.done && bus.err) both_seen = 1'b1;
        if (bus.done && bus.tx_valid && bus.tx_ready) done_accept_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_clk_oe(input logic lvl, input string tag);
        int n = 0;
        while (ps2_clk_oe !== lvl && n < 400) begin
            tick(1);
            n++;
        end
        check(tag, 32'(ps2_clk_oe), 32'(lvl));
    endtask

    task automatic start_send(input logic [7:0] d);
        int n = 0;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        do begin
            tick(1);
            n++;
        end while (bus.tx_ready && n < 100);
        bus.tx_valid = 1'b0;
        check("accept", 32'(bus.tx_ready), 32'd0);
    endtask

    task automatic dev_frame(input bit wait_oe, input bit do_ack, input int n_clocks,
                             output logic [10:0] bits);
        int n = 0;
        bits = '0;
        if (wait_oe) begin
            wait_clk_oe(1'b1, "clk_oe_high");
            wait_clk_oe(1'b0, "clk_oe_low");
        end
        tick(10);
        bits[0] = ps2_data_in;
        for (int i = 1; i <= 10 && i <= n_clocks; i++) begin
            dev_clk_low = 1'b1;
            tick(40);
            dev_clk_low = 1'b0;
            tick(1);
            bits[i] = ps2_data_in;
            tick(39);
        end
        if (n_clocks > 10) begin
            if (do_ack) dev_data_low = 1'b1;
            tick(10);
            dev_clk_low = 1'b1;
            tick(40);
            dev_clk_low = 1'b0;
            tick(5);
            dev_data_low = 1'b0;
            while (!(bus.done || bus.err) && n < 30) begin
                tick(1);
                n++;
            end
            tick(1);
        end
    endtask

    initial begin
        logic [10:0] bits;
        int d0, e0, a0, n, nd;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;

        tick(2);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b1;
        tick(5);

        d0 = done_cnt; e0 = err_cnt;
        start_send(8'hED);
        dev_frame(1'b1, 1'b1, 11, bits);
        check("ed_bits", 32'(bits), 32'(11'b1_1_11101101_0));
        tick(5);
        check("ed_done", 32'(done_cnt - d0), 32'd1);
        check("ed_err", 32'(err_cnt - e0), 32'd0);

        d0 = done_cnt; e0 = err_cnt;
        start_send(8'h07);
        wait_clk_oe(1'b1, "p07_clk_oe_high");
        wait_clk_oe(1'b0, "p07_clk_oe_low");
        tick(5);
        bus.tx_data  = 8'h55;
        bus.tx_valid = 1'b1;
        tick(3);
        bus.tx_valid = 1'b0;
        dev_frame(1'b0, 1'b1, 11, bits);
        check("p07_bits", 32'(bits), 32'(11'b1_0_00000111_0));
        check("p07_parity", 32'(bits[9]), 32'd0);
        tick(100);
        check("busy_pulse_ignored_ready", 32'(bus.tx_ready), 32'd1);
        check("busy_pulse_ignored_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("p07_done", 32'(done_cnt - d0), 32'd1);

        d0 = done_cnt;
        start_send(8'h00);
        n = 0; nd = -1;
        while (ps2_clk_oe && n < 100) begin
            if (ps2_data_oe && nd < 0) nd = n;
            tick(1);
            n++;
        end
        check("clk_oe_high_cycles", 32'(n), 32'd24);
        check("data_oe_rise_offset", 32'(nd), 32'd20);
        dev_frame(1'b0, 1'b1, 11, bits);
        check("p00_bits", 32'(bits), 32'(11'b1_1_00000000_0));
        check("p00_parity", 32'(bits[9]), 32'd1);
        tick(5);
        check("p00_done", 32'(done_cnt - d0), 32'd1);

        d0 = done_cnt; e0 = err_cnt;
        start_send(8'h55);
        dev_frame(1'b1, 1'b0, 11, bits);
        tick(60);
        check("noack_err", 32'(err_cnt - e0), 32'd1);
        check("noack_done", 32'(done_cnt - d0), 32'd0);
        check("noack_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("noack_data_oe", 32'(ps2_data_oe), 32'd0);
        check("noack_ready", 32'(bus.tx_ready), 32'd1);

        e0 = err_cnt;
        start_send(8'hAA);
        wait_clk_oe(1'b1, "silent_clk_oe_high");
        wait_clk_oe(1'b0, "silent_clk_oe_low");
        n = 0;
        while (!bus.err && n < 6000) begin
            tick(1);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd5000);
        check("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("timeout_data_oe", 32'(ps2_data_oe), 32'd0);
        tick(1);
        check("timeout_err_once", 32'(err_cnt - e0), 32'd1);
        check("timeout_ready", 32'(bus.tx_ready), 32'd1);

        d0 = done_cnt; e0 = err_cnt;
        start_send(8'h52);
        dev_frame(1'b1, 1'b1, 4, bits);
        check("rstmid_bits", 32'(bits[4:0]), 32'(5'b00100));
        check("rstmid_pre_data_oe", 32'(ps2_data_oe), 32'd1);
        #3 rst = 1'b0;
        #1;
        check("rstmid_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rstmid_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rstmid_ready", 32'(bus.tx_ready), 32'd1);
        tick(5);
        rst = 1'b1;
        tick(50);
        check("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
        check("rstmid_no_err", 32'(err_cnt - e0), 32'd0);
        start_send(8'hF4);
        dev_frame(1'b1, 1'b1, 11, bits);
        check("f4_bits", 32'(bits), 32'(11'b1_0_11110100_0));
        tick(5);
        check("f4_done", 32'(done_cnt - d0), 32'd1);

        d0 = done_cnt; e0 = err_cnt; a0 = done_accept_cnt;
        bus.tx_data  = 8'hED;
        bus.tx_valid = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (bus.tx_ready && n < 100);
        check("b2b_accept1", 32'(bus.tx_ready), 32'd0);
        bus.tx_data = 8'h02;
        dev_frame(1'b1, 1'b1, 11, bits);
        bus.tx_valid = 1'b0;
        check("b2b_bits1", 32'(bits), 32'(11'b1_1_11101101_0));
        check("b2b_accept_in_done", 32'(done_accept_cnt - a0), 32'd1);
        dev_frame(1'b1, 1'b1, 11, bits);
        check("b2b_bits2", 32'(bits), 32'(11'b1_0_00000010_0));
        tick(50);
        check("b2b_done", 32'(done_cnt - d0), 32'd2);
        check("b2b_err", 32'(err_cnt - e0), 32'd0);
        check("b2b_idle", 32'(bus.tx_ready), 32'd1);
        check("done_err_exclusive", 32'(both_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
